// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
// Holds the fetch FSM encoding, datapath widths and the reset/bubble defaults.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 64;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [PC_W-1:0]    RESET_PC_DEFAULT  = 64'h0;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // Redirect targets are forced onto a 4-byte instruction boundary.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & ~(PC_W'(3));
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
// Empty or flushed contents read as a bubble (valid=0, pc=0, NOP word).
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic               hold,
    input  logic [PC_W-1:0]    load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               valid,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (flush) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (load && !hold) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/instr_fetch_if_id.sv
// Instruction fetch stage: PC generation, single-outstanding imem fetch FSM and IF/ID register.
// A redirect from branch resolution outranks stall and every FSM action.
module instr_fetch_if_id
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               if_id_valid,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [INSTR_W-1:0] if_id_instruc,
    output logic [1:0]         dbg_state
);

    // Handshake: a request transfers on a rising edge where imem_req_valid and
    // imem_req_ready are both high; imem_req_valid holds until then. The memory
    // answers each transfer with exactly one imem_resp_valid pulse, at least one
    // cycle later, and never back-pressures the response.

    fetch_state_e        state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                drop_q, drop_d;
    logic [INSTR_W-1:0]  resp_buf_q, resp_buf_d;
    logic                ifid_load;
    logic [INSTR_W-1:0]  ifid_instr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            resp_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            resp_buf_q <= resp_buf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        resp_buf_d = resp_buf_q;
        ifid_load  = 1'b0;
        ifid_instr = imem_resp_data;

        case (state_q)
            ST_REQ: begin
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else if (!stall) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_q + PC_W'(4);
                        state_d   = ST_REQ;
                    end else begin
                        resp_buf_d = imem_resp_data;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    ifid_load  = 1'b1;
                    ifid_instr = resp_buf_q;
                    pc_d       = pc_q + PC_W'(4);
                    state_d    = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // Any fetch already in flight belongs to the wrong path and is marked for discard.
        if (branch_taken) begin
            pc_d       = align_pc(branch_target);
            ifid_load  = 1'b0;
            resp_buf_d = '0;
            case (state_q)
                ST_REQ: begin
                    if (imem_req_ready) begin
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    assign imem_req_valid = reset && (state_q == ST_REQ);
    assign imem_addr      = pc_q;
    assign dbg_state      = state_q;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (ifid_load),
        .flush      (branch_taken),
        .hold       (stall),
        .load_pc    (pc_q),
        .load_instr (ifid_instr),
        .valid      (if_id_valid),
        .pc         (if_id_pc),
        .instr      (if_id_instruc)
    );

endmodule
